// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and controller-state definitions for the
// sequential accumulator ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_ADC  = 4'd2,
        OP_SBB  = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_XOR  = 4'd6,
        OP_NOT  = 4'd7,
        OP_SHL  = 4'd8,
        OP_SHR  = 4'd9,
        OP_SAR  = 4'd10,
        OP_ROL  = 4'd11,
        OP_CMP  = 4'd12,
        OP_MUL  = 4'd13,
        OP_PASS = 4'd14,
        OP_INC  = 4'd15
    } op_e;

    localparam int FLAG_C = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier: one partial product per cycle, WIDTH steps.
// done is asserted during the last step, with prod already showing the final sum.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] psum;
    logic [2*WIDTH-1:0] psum_nxt;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               busy;

    assign psum_nxt = mplier[0] ? (psum + mcand) : psum;
    assign done     = busy && (cnt == CW'(1));
    assign prod     = psum_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            psum   <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            psum   <= '0;
            cnt    <= CW'(WIDTH);
            busy   <= 1'b1;
        end else if (busy) begin
            psum   <= psum_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq_acc.sv
// Registered ALU with valid/ready handshake, persistent {C,Z,N,V} flags,
// accumulator operand and a multi-cycle multiply.
//
// state | meaning
// IDLE  | accepting ops; single-cycle ops retire on the edge after accept
// MUL   | multiplier stepping; in_ready low until the product registers
module alu_seq_acc
    import alu_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acc_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x,
    output logic [3:0]       flags,
    output logic [WIDTH-1:0] acc
);
    localparam logic [SHW:0] WIDTH_S = (SHW + 1)'(WIDTH);

    state_e             state;
    state_e             state_nxt;
    op_e                op_sel;
    logic [WIDTH-1:0]   a_eff;
    logic               accept;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] prod;
    logic               complete;

    logic [WIDTH-1:0]   res;
    logic               c_new;
    logic               v_new;
    logic [WIDTH-1:0]   b_op;
    logic               cin;
    logic [WIDTH:0]     wide;
    logic [SHW-1:0]     amt;
    logic [2*WIDTH-1:0] rot_t;

    assign a_eff     = acc_sel ? acc : a;
    assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (op_e'(op) == OP_MUL);
    // While multiplying, the op input is don't-care; the result path must follow MUL.
    assign op_sel    = (state == MUL) ? OP_MUL : op_e'(op);
    assign complete  = (accept && !mul_start) || ((state == MUL) && mul_done);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .a     (a_eff),
        .b     (b),
        .done  (mul_done),
        .prod  (prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (mul_start) state_nxt = MUL;
            MUL:  if (mul_done)  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        res   = '0;
        c_new = 1'b0;
        v_new = 1'b0;
        b_op  = b;
        cin   = 1'b0;
        wide  = '0;
        rot_t = '0;
        amt   = b[SHW-1:0];
        if ({1'b0, amt} >= WIDTH_S) amt = amt - WIDTH_S[SHW-1:0];
        case (op_sel)
            OP_ADD, OP_ADC, OP_INC: begin
                if (op_sel == OP_INC) b_op = {{(WIDTH-1){1'b0}}, 1'b1};
                if (op_sel == OP_ADC) cin = flags[FLAG_C];
                wide  = {1'b0, a_eff} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
                res   = wide[WIDTH-1:0];
                c_new = wide[WIDTH];
                v_new = (a_eff[WIDTH-1] == b_op[WIDTH-1]) && (res[WIDTH-1] != a_eff[WIDTH-1]);
            end
            OP_SUB, OP_SBB, OP_CMP: begin
                if (op_sel == OP_SBB) cin = flags[FLAG_C];
                wide  = {1'b0, a_eff} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
                res   = wide[WIDTH-1:0];
                c_new = wide[WIDTH];
                v_new = (a_eff[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a_eff[WIDTH-1]);
            end
            OP_AND:  res = a_eff & b;
            OP_OR:   res = a_eff | b;
            OP_XOR:  res = a_eff ^ b;
            OP_NOT:  res = ~a_eff;
            OP_PASS: res = b;
            // A guard bit beside the operand catches the last bit shifted out.
            OP_SHL: begin
                wide  = {1'b0, a_eff} << amt;
                res   = wide[WIDTH-1:0];
                c_new = wide[WIDTH];
            end
            OP_SHR: begin
                wide  = {a_eff, 1'b0} >> amt;
                res   = wide[WIDTH:1];
                c_new = wide[0];
            end
            OP_SAR: begin
                wide  = $signed({a_eff, 1'b0}) >>> amt;
                res   = wide[WIDTH:1];
                c_new = wide[0];
            end
            OP_ROL: begin
                rot_t = {a_eff, a_eff} << amt;
                res   = rot_t[2*WIDTH-1:WIDTH];
                c_new = (amt != '0) && res[0];
            end
            OP_MUL: begin
                res   = prod[WIDTH-1:0];
                c_new = |prod[2*WIDTH-1:WIDTH];
                v_new = c_new;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x         <= '0;
            flags     <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
        end else if (complete) begin
            out_valid       <= 1'b1;
            flags[FLAG_C]   <= c_new;
            flags[FLAG_Z]   <= (res == '0);
            flags[FLAG_N]   <= res[WIDTH-1];
            flags[FLAG_V]   <= v_new;
            if (op_sel != OP_CMP) begin
                x   <= res;
                acc <= res;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq_acc.sv
// Bench for alu_seq_acc at WIDTH=4: directed scenarios plus a random op stream,
// with results scored against an independent integer model through a queue.
module tb_alu_seq_acc;
    localparam int W = 4;

    typedef struct {
        logic [W-1:0] x;
        logic [3:0]   f;
        logic [W-1:0] acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         acc_sel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] x;
    logic [3:0]   flags;
    logic [W-1:0] acc;

    exp_t         exp_q[$];
    int           n_vec  = 0;
    int           n_miss = 0;
    logic [W-1:0] m_x;
    logic [W-1:0] m_acc;
    logic         m_c;

    always #5 clk = ~clk;

    alu_seq_acc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .acc_sel   (acc_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x),
        .flags     (flags),
        .acc       (acc)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t         e;
        int           ua, ub, sa, sbv, ci, full, ss, amt;
        longint       p;
        logic [W-1:0] r;
        logic         c, v;
        ua   = int'(av);
        ub   = int'(bv);
        sa   = av[W-1] ? ua - (1 << W) : ua;
        sbv  = bv[W-1] ? ub - (1 << W) : ub;
        ci   = int'(m_c);
        amt  = (ub % (1 << $clog2(W))) % W;
        r    = '0;
        c    = 1'b0;
        v    = 1'b0;
        full = 0;
        ss   = 0;
        p    = 0;
        case (o)
            4'd0, 4'd2, 4'd15: begin
                if (o == 4'd15) begin ub = 1; sbv = 1; end
                if (o != 4'd2) ci = 0;
                full = ua + ub + ci;
                ss   = sa + sbv + ci;
                r    = full[W-1:0];
                c    = (full >= (1 << W));
                v    = (ss > (1 << (W-1)) - 1) || (ss < -(1 << (W-1)));
            end
            4'd1, 4'd3, 4'd12: begin
                if (o != 4'd3) ci = 0;
                full = ua - ub - ci;
                ss   = sa - sbv - ci;
                r    = full[W-1:0];
                c    = (full < 0);
                v    = (ss > (1 << (W-1)) - 1) || (ss < -(1 << (W-1)));
            end
            4'd4:  r = av & bv;
            4'd5:  r = av | bv;
            4'd6:  r = av ^ bv;
            4'd7:  r = ~av;
            4'd14: r = bv;
            4'd8: begin
                r = av;
                for (int i = 0; i < amt; i++) begin c = r[W-1]; r = {r[W-2:0], 1'b0}; end
            end
            4'd9: begin
                r = av;
                for (int i = 0; i < amt; i++) begin c = r[0]; r = {1'b0, r[W-1:1]}; end
            end
            4'd10: begin
                r = av;
                for (int i = 0; i < amt; i++) begin c = r[0]; r = {r[W-1], r[W-1:1]}; end
            end
            4'd11: begin
                r = av;
                for (int i = 0; i < amt; i++) begin r = {r[W-2:0], r[W-1]}; c = r[0]; end
            end
            4'd13: begin
                p = longint'(ua) * longint'(ub);
                r = p[W-1:0];
                c = ((p >> W) != 0);
                v = c;
            end
            default: ;
        endcase
        e.f   = {c, (r == '0), r[W-1], v};
        e.x   = (o == 4'd12) ? m_x   : r;
        e.acc = (o == 4'd12) ? m_acc : r;
        return e;
    endfunction

    // Present one op; returns one time unit after the accepting edge.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic sel, input bit rnd);
        exp_t e;
        int   waited;
        waited   = 0;
        op       = o;
        a        = av;
        b        = bv;
        acc_sel  = sel;
        in_valid = 1'b1;
        if (rnd) out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        while (!in_ready && waited < 40) begin
            @(posedge clk); #1;
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("accept_timeout", int'(in_ready), 1);
            in_valid = 1'b0;
            return;
        end
        e = model(o, sel ? m_acc : av, bv);
        exp_q.push_back(e);
        m_c   = e.f[3];
        m_x   = e.x;
        m_acc = e.acc;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("sb_x",     int'(x),     int'(e.x));
                check("sb_flags", int'(flags), int'(e.f));
                check("sb_acc",   int'(acc),   int'(e.acc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = '0;
        a         = '0;
        b         = '0;
        acc_sel   = 1'b0;
        out_ready = 1'b1;
        m_x       = '0;
        m_acc     = '0;
        m_c       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_x",     int'(x),         0);
        check("rst_flags", int'(flags),     0);
        check("rst_acc",   int'(acc),       0);
        check("rst_ovld",  int'(out_valid), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ADD, SUB, CMP back to back
        issue(4'd0, 4'b1100, 4'b1010, 1'b0, 1'b0);
        check("add_x",     int'(x),         'b0110);
        check("add_flags", int'(flags),     'b1001);
        check("add_ovld",  int'(out_valid), 1);
        check("add_acc",   int'(acc),       'b0110);
        issue(4'd1, 4'b1100, 4'b1010, 1'b0, 1'b0);
        check("sub_x", int'(x),        'b0010);
        check("sub_c", int'(flags[3]), 0);
        check("sub_v", int'(flags[0]), 0);
        issue(4'd12, 4'b0011, 4'b0101, 1'b0, 1'b0);
        check("cmp_x",     int'(x),     'b0010);
        check("cmp_flags", int'(flags), 'b1010);
        check("cmp_acc",   int'(acc),   'b0010);

        // MUL: four busy cycles, a competing request must not be taken
        issue(4'd13, 4'b1100, 4'b1010, 1'b0, 1'b0);
        op       = 4'd14;
        a        = '0;
        b        = 4'b0001;
        acc_sel  = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            check("mul_busy_rdy", int'(in_ready), 0);
        end
        check("mul_busy_ovld", int'(out_valid), 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mul_ovld",  int'(out_valid), 1);
        check("mul_x",     int'(x),         'b1000);
        check("mul_flags", int'(flags),     'b1011);
        check("mul_rdy",   int'(in_ready),  1);
        @(posedge clk); #1;

        // backpressure, then consume + accept on one edge
        out_ready = 1'b0;
        issue(4'd0, 4'b0011, 4'b0011, 1'b0, 1'b0);
        check("bp_x", int'(x), 'b0110);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("bp_hold_x",     int'(x),         'b0110);
            check("bp_hold_flags", int'(flags),     0);
            check("bp_hold_rdy",   int'(in_ready),  0);
            check("bp_hold_ovld",  int'(out_valid), 1);
        end
        out_ready = 1'b1;
        issue(4'd15, 4'b0110, 4'b0000, 1'b0, 1'b0);
        check("bp_inc_ovld", int'(out_valid), 1);
        check("bp_inc_x",    int'(x),         'b0111);

        // reset two cycles into a multiply
        issue(4'd13, 4'b0101, 4'b0011, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        m_x   = '0;
        m_acc = '0;
        m_c   = 1'b0;
        #1;
        check("mrst_ovld",  int'(out_valid), 0);
        check("mrst_acc",   int'(acc),       0);
        check("mrst_flags", int'(flags),     0);
        check("mrst_x",     int'(x),         0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mrst_rdy", int'(in_ready), 1);
        for (int k = 0; k < W + 3; k++) begin
            @(posedge clk); #1;
            check("mrst_no_stale", int'(out_valid), 0);
        end

        // accumulator chain with carry through ADC/SBB
        issue(4'd14, 4'b0000, 4'b0011, 1'b0, 1'b0);
        check("chain_pass", int'(x), 'b0011);
        issue(4'd0, 4'b0000, 4'b0001, 1'b1, 1'b0);
        check("chain_add", int'(x), 'b0100);
        issue(4'd2, 4'b0000, 4'b1111, 1'b1, 1'b0);
        check("chain_adc_x", int'(x),        'b0011);
        check("chain_adc_c", int'(flags[3]), 1);
        issue(4'd3, 4'b0000, 4'b0000, 1'b1, 1'b0);
        check("chain_sbb", int'(x), 'b0010);

        // random stream with random backpressure
        for (int n = 0; n < 150; n++) begin
            issue(4'($urandom_range(0, 15)), W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'b1);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        check("sb_drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/alu_seq_acc.md
Name: alu_seq_acc

Overview:
- Parametrised successor to the 4-bit combinational ALU: WIDTH-bit datapath, same 4-bit opcode space.
- Adds registered outputs, a valid/ready handshake on input and output, a persistent flag register (C, Z, N, V) and an accumulator operand.
- Multiply is a multi-cycle sequential operation.
- Sits between the instruction sequencer and the register file; consumes one operation per accepted handshake.

Parameters:
- WIDTH, 8, operand/result width in bits (≥ 4).
- SHW, $clog2(WIDTH), shift-amount width. Derived; not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept an operation this cycle.
- op  in  4  opcode, encoded per alu_pkg.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- acc_sel  in  1  1: internal accumulator replaces operand A.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer takes the result.
- x  out  WIDTH  result.
- flags  out  4  {C, Z, N, V}.
- acc  out  WIDTH  current accumulator value.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values: x=0, flags=0, acc=0, out_valid=0, FSM=IDLE, multiplier state cleared.
  - Reset asserted mid-MUL aborts the operation. No result is produced.
- Accept condition: in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready). Purely combinational; does not depend on in_valid.
- Output hold: while out_valid && !out_ready, x and flags hold stable.
- Output consume: out_valid drops on the consume edge unless a new result lands on the same edge.
- Latency, single-cycle ops: x, flags and out_valid update on the edge after acceptance. Back-to-back throughput is 1 op/cycle.
- Latency, MUL (op 13): FSM IDLE→MUL on accept. One shift-add step per cycle for WIDTH cycles. The result registers on the WIDTH-th edge after acceptance, then MUL→IDLE. in_ready=0 throughout MUL.
- Operand A source: A_eff = acc_sel ? acc : a.
- Accumulator write: every completed op except CMP writes x into acc, on the same edge as x. A following op with acc_sel=1 sees the new value (no hazard).
- Opcodes (A_eff op b):
  - 0 ADD, 1 SUB, 2 ADC (+C), 3 SBB (−C).
  - 4 AND, 5 OR, 6 XOR, 7 NOT A.
  - 8 SHL, 9 SHR logical, 10 SAR, 11 ROL.
  - 12 CMP (flags of A−b; x and acc unchanged).
  - 13 MUL (low WIDTH bits, unsigned), 14 PASS B, 15 INC A.
- Arithmetic: computed at WIDTH+1 bits.
  - ADD/ADC/INC: C = carry out.
  - SUB/SBB/CMP: C = borrow (1 when A < b+cin, unsigned).
  - V = signed overflow, two's complement.
- Logic ops and PASS: C=0, V=0.
- Shifts: amount = b[SHW-1:0] (mod WIDTH).
  - C = last bit shifted out, or 0 when amount = 0. V=0.
  - ROL: C = bit rotated into the LSB.
- MUL: C = V = (high half of the 2·WIDTH product ≠ 0).
- All ops: Z = (result==0), N = result[WIDTH-1]. For CMP these apply to the difference.
- Flag register: flags persist between ops and update only when an op completes. ADC/SBB use the registered C from the previous completed op.
- Simultaneous consume + accept: accepted and retired on the same edge; out_valid stays 1 with the new result.
- Illegal states: none; all 16 opcodes are defined.

Decomposition:
- alu_pkg: op_e enum (16 entries above), flag bit indices FLAG_C=3, FLAG_Z=2, FLAG_N=1, FLAG_V=0, state_e {IDLE, MUL}.
- Sub-module alu_mul_seq (shift-add multiplier):
  - ports: clk, rst_n, start, a, b → done, prod[2·WIDTH-1:0].
  - top level holds the FSM, handshake, flag and accumulator registers.

Test Plan:
- WIDTH=4, a=1100, b=1010, ADD, out_ready=1 → next cycle x=0110, C=1, Z=0, N=0, V=1, out_valid=1, acc=0110.
- Same operands SUB, then CMP a=0011 b=0101 → SUB: x=0010, C=0, V=0. CMP: x stays 0010, C=1, N=1, acc stays 0010.
- MUL a=1100 b=1010 accepted at edge T → in_ready=0 for 4 cycles; x=1000, C=V=1, out_valid at edge T+4; a second in_valid during MUL is not accepted.
- Backpressure: ADD completes with out_ready=0 for 3 cycles → x/flags stable, in_ready=0; out_ready=1 with in_valid (INC) → consume and accept on the same edge, out_valid stays 1, x=0111.
- Accumulator chain from reset: PASS b=0011, then acc_sel=1 ADD b=0001, then ADC b=1111 with acc_sel=1 → x=0011, 0100, then 0011 with C=1; next SBB acc_sel=1 b=0000 → x=0010.
- rst_n low 2 cycles into MUL → immediately out_valid=0, acc=0, flags=0; after release in_ready=1, no stale result appears.
